// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate sweep sequencer and its golden model.
// Holds the sequencer state encoding, default sizing and a constant log2 helper.
package gate_test_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } sweepStateT;

   localparam int N_IN_DEF  = 2;
   localparam int DWELL_DEF = 4;

   // Ceiling log2, used at elaboration time to size the dwell counter.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/nor_golden.sv
// Golden reference for an N-input NOR gate, written in De Morgan form.
// The sequencer compares the gate under test against this output.
module nor_golden #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0] x,
   output logic            y
);

   // AND of the inverted inputs is logically identical to NOR, but built differently.
   assign y = &(~x);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps an N-input NOR gate under test through every input vector, holds each for
// DWELL cycles, samples the gate and records mismatch count and first failing vector.
module gate_sweep_ctrl
   import gate_test_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int DWELL = DWELL_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] vec,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec,
   output logic            aborted
);

   // A DWELL of 1 needs no counting, but the counter still needs at least one bit.
   localparam int CNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [N_IN:0]    ERR_MAX    = {1'b1, {N_IN{1'b0}}};

   sweepStateT       state;
   logic [CNT_W-1:0] dwellCnt;
   logic             goldenY;

   // The golden value always tracks the vector currently applied to the gate under test.
   nor_golden #(
      .N_IN(N_IN)
   ) golden (
      .x(vec),
      .y(goldenY)
   );

   // Sequencer: a sweep starts from IDLE, alternates SETTLE (hold the vector for DWELL
   // cycles) and SAMPLE (compare gate against golden, then advance), and ends with a
   // one-cycle DONE that latches the pass verdict. An abort during the sweep drops
   // straight back to IDLE, discards any compare of that cycle and keeps partial results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dwellCnt   <= '0;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         aborted    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  dwellCnt   <= '0;
                  vec        <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  aborted    <= 1'b0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  vec      <= '0;
                  dwellCnt <= '0;
                  aborted  <= 1'b1;
               end else if (dwellCnt == DWELL_LAST) begin
                  state <= SAMPLE;
               end else begin
                  dwellCnt <= dwellCnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  vec      <= '0;
                  dwellCnt <= '0;
                  aborted  <= 1'b1;
               end else begin
                  if (dut_y != goldenY) begin
                     if (err_count != ERR_MAX) begin
                        err_count <= err_count + 1'b1;
                     end
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                     end
                  end
                  if (&vec) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     vec      <= vec + 1'b1;
                     dwellCnt <= '0;
                     state    <= SETTLE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               pass  <= (err_count == '0);
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
